// File: rtl/sprite_rom_arbiter.sv
// Round-robin valid/ready arbiter sharing one synchronous sprite ROM across NREQ requesters.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sprite_rom_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                     vga_clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]        rom_address,
    input  logic [DATA_W-1:0]        rom_q,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data
);

    localparam int unsigned    IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     cand;
    logic               found;
    logic               accept;
    logic [ROM_LAT-1:0] tag_valid_q;
    logic [IDW-1:0]     tag_id_q [ROM_LAT];

    // Searching in reverse order lets the last hit be the highest-priority candidate.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'(k);
            if (req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_grant_q) + k) % int'(NREQ));
            if (req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`endif
    end

    always_comb begin
        accept      = found && !reset;
        req_ready   = accept ? (NREQ'(1) << winner) : '0;
        rom_address = req_addr[winner*ADDR_W +: ADDR_W];
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`else
        last_grant_d = accept ? winner : last_grant_q;
`endif
    end

    // Tags travel alongside the ROM read so each word returns to its originator.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= LAST_ID;
            tag_valid_q  <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            tag_valid_q[0] <= accept;
            tag_id_q[0]    <= winner;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
            rsp_valid <= tag_valid_q[ROM_LAT-1] ? (NREQ'(1) << tag_id_q[ROM_LAT-1]) : '0;
            rsp_data  <= rom_q;
        end
    end

endmodule
